// File: rtl/div_pkg.sv
// Shared types, widths and helpers for the multicycle restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;
    // Widest operand the sign-extension helper handles (WIDTH must stay below this).
    localparam int unsigned DIV_MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return 32'($clog2(w + 1));
    endfunction

    // Magnitude of a sign-extended operand; |MIN| wraps to 2^(WIDTH-1) after truncation.
    function automatic logic [DIV_MAX_WIDTH-1:0] abs_val(input logic [DIV_MAX_WIDTH-1:0] value,
                                                         input logic                     is_signed);
        if (is_signed && value[DIV_MAX_WIDTH-1]) begin
            return -value;
        end
        return value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Shifted remainder needs one extra bit; a successful subtract always fits WIDTH bits.
    assign wide     = {rem, quo[WIDTH-1]};
    assign ge       = (wide >= {1'b0, dvs});
    assign diff     = wide[WIDTH-1:0] - dvs;
    assign rem_next = ge ? diff : wide[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Multicycle radix-2 restoring divider (DIV/DIVU/REM/REMU semantics).
// Define DIV_EARLY_OUT_EN to bypass the iteration loop for trivially small quotients.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned      CNT_W   = cnt_width(WIDTH);
    localparam int unsigned      PAD_W   = DIV_MAX_WIDTH - WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic             negq, negq_n;
    logic             negr, negr_n;
    logic             dzero, dzero_n;
    logic             ovf, ovf_n;
    logic             busy_n, done_n;
    logic [WIDTH-1:0] quotient_n, remainder_n;

    logic [DIV_MAX_WIDTH-1:0] dd_ext, dv_ext;
    logic [WIDTH-1:0]         dd_mag, dv_mag;
    logic [WIDTH-1:0]         step_rem, step_quo;

    // Operand magnitudes, formed combinationally so they can be latched on the accepting edge.
    assign dd_ext = {{PAD_W{is_signed & dividend[WIDTH-1]}}, dividend};
    assign dv_ext = {{PAD_W{is_signed & divisor[WIDTH-1]}}, divisor};
    assign dd_mag = WIDTH'(abs_val(dd_ext, is_signed));
    assign dv_mag = WIDTH'(abs_val(dv_ext, is_signed));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rem_n       = rem;
        quo_n       = quo;
        dvs_n       = dvs;
        negq_n      = negq;
        negr_n      = negr;
        dzero_n     = dzero;
        ovf_n       = ovf;
        busy_n      = busy;
        done_n      = 1'b0;
        quotient_n  = quotient;
        remainder_n = remainder;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                if (start) begin
                    state_n = RUN;
                    busy_n  = 1'b1;
                    cnt_n   = CNT_W'(WIDTH);
                    rem_n   = '0;
                    quo_n   = dd_mag;
                    dvs_n   = dv_mag;
                    negq_n  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    negr_n  = is_signed & dividend[WIDTH-1];
                    dzero_n = (divisor == '0);
                    ovf_n   = is_signed && (dividend == MIN_VAL) && (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
                    // Quotient is already known to be zero (or all ones on divide by zero).
                    if ((divisor == '0) || (dd_mag < dv_mag)) begin
                        state_n = FIX;
                        rem_n   = dd_mag;
                        quo_n   = '0;
                    end
`endif
                end
            end
            RUN: begin
                rem_n = step_rem;
                quo_n = step_quo;
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                // Remainder correction also restores the dividend exactly on divide by zero.
                remainder_n = negr ? -rem : rem;
                if (dzero) begin
                    quotient_n = '1;
                end else if (ovf) begin
                    quotient_n  = MIN_VAL;
                    remainder_n = '0;
                end else begin
                    quotient_n = negq ? -quo : quo;
                end
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            negq      <= 1'b0;
            negr      <= 1'b0;
            dzero     <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rem       <= rem_n;
            quo       <= quo_n;
            dvs       <= dvs_n;
            negq      <= negq_n;
            negr      <= negr_n;
            dzero     <= dzero_n;
            ovf       <= ovf_n;
            busy      <= busy_n;
            done      <= done_n;
            quotient  <= quotient_n;
            remainder <= remainder_n;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32).
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int LAT_FULL = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_DZ = 1;
`else
    localparam int LAT_DZ = 33;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic do_op(input logic [31:0] dd, input logic [31:0] dv, input logic sg,
                         output logic [31:0] q, output logic [31:0] r,
                         output int lat, output logic busy_at_done);
        start     = 1'b1;
        dividend  = dd;
        divisor   = dv;
        is_signed = sg;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 100);
        q            = quotient;
        r            = remainder;
        busy_at_done = busy;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (quotient !== 32'h0)  begin n_bad++; $display("FAIL reset_q: got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL reset_r: got %h want 0", remainder); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r; int lat; logic b;
        do_op(32'd100, 32'd7, 1'b0, q, r, lat, b);
        n_cmp++; if (q !== 32'd14)     begin n_bad++; $display("FAIL u100_7_q: got %h want %h", q, 32'd14); end
        n_cmp++; if (r !== 32'd2)      begin n_bad++; $display("FAIL u100_7_r: got %h want %h", r, 32'd2); end
        n_cmp++; if (lat != LAT_FULL)  begin n_bad++; $display("FAIL u100_7_lat: got %0d want %0d", lat, LAT_FULL); end
        n_cmp++; if (b !== 1'b0)       begin n_bad++; $display("FAIL u100_7_busy_at_done: got %b want 0", b); end
        @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL u100_7_done_width: got %b want 0", done); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (quotient !== 32'd14) begin n_bad++; $display("FAIL u100_7_hold: got %h want %h", quotient, 32'd14); end
        do_op(32'hFFFFFFF9, 32'd2, 1'b0, q, r, lat, b);
        n_cmp++; if (q !== 32'h7FFFFFFC) begin n_bad++; $display("FAIL uF9_2_q: got %h want 7ffffffc", q); end
        n_cmp++; if (r !== 32'h1)        begin n_bad++; $display("FAIL uF9_2_r: got %h want 1", r); end
    endtask

    task automatic test_signed();
        logic [31:0] q, r; int lat; logic b;
        do_op(32'hFFFFFFF9, 32'd2, 1'b1, q, r, lat, b);
        n_cmp++; if (q !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL s_m7_2_q: got %h want fffffffd", q); end
        n_cmp++; if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL s_m7_2_r: got %h want ffffffff", r); end
        n_cmp++; if (lat != LAT_FULL)    begin n_bad++; $display("FAIL s_m7_2_lat: got %0d want %0d", lat, LAT_FULL); end
        do_op(32'd7, 32'hFFFFFFFE, 1'b1, q, r, lat, b);
        n_cmp++; if (q !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL s_7_m2_q: got %h want fffffffd", q); end
        n_cmp++; if (r !== 32'h1)        begin n_bad++; $display("FAIL s_7_m2_r: got %h want 1", r); end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; int lat; logic b;
        for (int m = 0; m < 2; m++) begin
            do_op(32'h12345678, 32'h0, m[0], q, r, lat, b);
            n_cmp++; if (q !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dz_q mode%0d: got %h want ffffffff", m, q); end
            n_cmp++; if (r !== 32'h12345678) begin n_bad++; $display("FAIL dz_r mode%0d: got %h want 12345678", m, r); end
            n_cmp++; if (lat != LAT_DZ)      begin n_bad++; $display("FAIL dz_lat mode%0d: got %0d want %0d", m, lat, LAT_DZ); end
        end
        do_op(32'h80000000, 32'h0, 1'b1, q, r, lat, b);
        n_cmp++; if (q !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dz_min_q: got %h want ffffffff", q); end
        n_cmp++; if (r !== 32'h80000000) begin n_bad++; $display("FAIL dz_min_r: got %h want 80000000", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] q, r; int lat; logic b;
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, q, r, lat, b);
        n_cmp++; if (q !== 32'h80000000) begin n_bad++; $display("FAIL ovf_q: got %h want 80000000", q); end
        n_cmp++; if (r !== 32'h0)        begin n_bad++; $display("FAIL ovf_r: got %h want 0", r); end
        n_cmp++; if (lat != LAT_FULL)    begin n_bad++; $display("FAIL ovf_lat: got %0d want %0d", lat, LAT_FULL); end
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, q, r, lat, b);
        n_cmp++; if (q !== 32'h0)        begin n_bad++; $display("FAIL u_min_q: got %h want 0", q); end
        n_cmp++; if (r !== 32'h80000000) begin n_bad++; $display("FAIL u_min_r: got %h want 80000000", r); end
    endtask

    task automatic test_ignore_start();
        int lat; logic busy_mid;
        start = 1'b1; dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_mid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin
                start = 1'b1; dividend = 32'd77; divisor = 32'd5; is_signed = 1'b1;
            end
            if (lat == 6) begin
                start    = 1'b0;
                busy_mid = busy;
            end
        end while (!done && lat < 100);
        n_cmp++; if (busy_mid !== 1'b1)    begin n_bad++; $display("FAIL ign_busy: got %b want 1", busy_mid); end
        n_cmp++; if (quotient !== 32'd100) begin n_bad++; $display("FAIL ign_q: got %h want %h", quotient, 32'd100); end
        n_cmp++; if (remainder !== 32'd0)  begin n_bad++; $display("FAIL ign_r: got %h want 0", remainder); end
        n_cmp++; if (lat != LAT_FULL)      begin n_bad++; $display("FAIL ign_lat: got %0d want %0d", lat, LAT_FULL); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r, q2, r2; int lat; logic b;
        do_op(32'd50, 32'd6, 1'b0, q, r, lat, b);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b want 1", done); end
        // Start issued while the DONE cycle is on the bus.
        do_op(32'hFFFFFF9C, 32'd7, 1'b1, q2, r2, lat, b);
        n_cmp++; if (q !== 32'd8)          begin n_bad++; $display("FAIL b2b_q1: got %h want 8", q); end
        n_cmp++; if (r !== 32'd2)          begin n_bad++; $display("FAIL b2b_r1: got %h want 2", r); end
        n_cmp++; if (q2 !== 32'hFFFFFFF2)  begin n_bad++; $display("FAIL b2b_q2: got %h want fffffff2", q2); end
        n_cmp++; if (r2 !== 32'hFFFFFFFE)  begin n_bad++; $display("FAIL b2b_r2: got %h want fffffffe", r2); end
        n_cmp++; if (lat != LAT_FULL)      begin n_bad++; $display("FAIL b2b_lat: got %0d want %0d", lat, LAT_FULL); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r; int lat; logic b; int seen_done;
        start = 1'b1; dividend = 32'h12345678; divisor = 32'd3; is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
        n_cmp++; if (quotient !== 32'h0)  begin n_bad++; $display("FAIL mid_q: got %h want 0", quotient); end
        n_cmp++; if (remainder !== 32'h0) begin n_bad++; $display("FAIL mid_r: got %h want 0", remainder); end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_cmp++; if (seen_done != 0) begin n_bad++; $display("FAIL mid_abort: got %0d active cycles want 0", seen_done); end
        do_op(32'hFFFFFFFF, 32'h10, 1'b0, q, r, lat, b);
        n_cmp++; if (q !== 32'h0FFFFFFF) begin n_bad++; $display("FAIL post_q: got %h want 0fffffff", q); end
        n_cmp++; if (r !== 32'hF)        begin n_bad++; $display("FAIL post_r: got %h want f", r); end
        n_cmp++; if (lat != LAT_FULL)    begin n_bad++; $display("FAIL post_lat: got %0d want %0d", lat, LAT_FULL); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
